// File: rtl/alu_pkg.sv
// Opcode map and datapath width shared by the ALU issue stage and the ALU it drives.
package alu_pkg;

   localparam int DW = 32;

   localparam logic [6:0] OP_ADD  = 7'h00;
   localparam logic [6:0] OP_SUB  = 7'h01;
   localparam logic [6:0] OP_MUL  = 7'h02;
   localparam logic [6:0] OP_DIV  = 7'h03;
   localparam logic [6:0] OP_AND  = 7'h04;
   localparam logic [6:0] OP_OR   = 7'h05;
   localparam logic [6:0] OP_XOR  = 7'h06;
   localparam logic [6:0] OP_NOR  = 7'h07;
   localparam logic [6:0] OP_SLL  = 7'h08;
   localparam logic [6:0] OP_SRL  = 7'h09;
   localparam logic [6:0] OP_SRA  = 7'h0A;
   localparam logic [6:0] OP_LAST = OP_SRA;

   function automatic logic is_illegal(input logic [6:0] op);
      return op > OP_LAST;
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: two combinational read ports, one synchronous write port, r0 hard-wired to zero.
module alu_regfile
   import alu_pkg::*;
#(
   parameter int NREGS = 16,
   parameter int AW    = $clog2(NREGS),
   parameter int RDW   = DW
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [AW-1:0]  rd_addr_a,
   output logic [RDW-1:0] rd_data_a,
   input  logic [AW-1:0]  rd_addr_b,
   output logic [RDW-1:0] rd_data_b,
   input  logic           wr_en,
   input  logic [AW-1:0]  wr_addr,
   input  logic [RDW-1:0] wr_data
);

   logic [RDW-1:0] mem_q [NREGS];
   logic [RDW-1:0] mem_d [NREGS];

   always_comb begin
      mem_d = mem_q;
      if (wr_en && (wr_addr != '0)) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_data_a = (rd_addr_a == '0) ? '0 : mem_q[rd_addr_a];
   assign rd_data_b = (rd_addr_b == '0) ? '0 : mem_q[rd_addr_b];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/writeback stage around an external combinational ALU: operand read with
// forwarding at issue, one E-stage slot, retirement with error pulses and a retire counter.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int NREGS = 16,
   parameter int AW    = $clog2(NREGS),
   parameter int SDW   = DW
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [6:0]     in_op,
   input  logic [AW-1:0]  in_rd,
   input  logic [AW-1:0]  in_rs1,
   input  logic [AW-1:0]  in_rs2,
   input  logic           in_use_imm,
   input  logic [SDW-1:0] in_imm,
   output logic [SDW-1:0] alu_a,
   output logic [SDW-1:0] alu_b,
   output logic [6:0]     alu_op,
   input  logic [SDW-1:0] alu_result,
   output logic           wb_valid,
   input  logic           wb_ready,
   output logic [AW-1:0]  wb_rd,
   output logic [SDW-1:0] wb_data,
   output logic           err_illegal,
   output logic           err_div0,
   output logic [31:0]    retire_count
);

   logic           e_valid_q, e_valid_d;
   logic [AW-1:0]  e_rd_q, e_rd_d;
   logic           e_illegal_q, e_illegal_d;
   logic [SDW-1:0] alu_a_q, alu_a_d;
   logic [SDW-1:0] alu_b_q, alu_b_d;
   logic [6:0]     alu_op_q, alu_op_d;
   logic [31:0]    retire_count_q, retire_count_d;
   logic           err_illegal_q, err_illegal_d;
   logic           err_div0_q, err_div0_d;

   logic           retire, accept, div0, suppress, fwd_ok;
   logic [SDW-1:0] rf_a, rf_b, opnd_a, opnd_b;

   alu_regfile #(.NREGS(NREGS), .AW(AW), .RDW(SDW)) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .rd_addr_a (in_rs1),
      .rd_data_a (rf_a),
      .rd_addr_b (in_rs2),
      .rd_data_b (rf_b),
      .wr_en     (retire && !suppress),
      .wr_addr   (e_rd_q),
      .wr_data   (alu_result)
   );

   assign div0     = (alu_op_q == OP_DIV) && (alu_b_q == '0);
   assign suppress = e_illegal_q || div0;
   assign retire   = e_valid_q && wb_ready;
   assign in_ready = !e_valid_q || wb_ready;
   assign accept   = in_valid && in_ready;
   // rd==0 never matches a nonzero rs, so r0 writes can not leak through forwarding
   assign fwd_ok   = retire && !suppress;

   always_comb begin
      opnd_a = rf_a;
      if (in_rs1 == '0) begin
         opnd_a = '0;
      end else if (fwd_ok && (e_rd_q == in_rs1)) begin
         opnd_a = alu_result;
      end

      opnd_b = rf_b;
      if (in_use_imm) begin
         opnd_b = in_imm;
      end else if (in_rs2 == '0) begin
         opnd_b = '0;
      end else if (fwd_ok && (e_rd_q == in_rs2)) begin
         opnd_b = alu_result;
      end
   end

   always_comb begin
      e_valid_d      = e_valid_q;
      e_rd_d         = e_rd_q;
      e_illegal_d    = e_illegal_q;
      alu_a_d        = alu_a_q;
      alu_b_d        = alu_b_q;
      alu_op_d       = alu_op_q;
      retire_count_d = retire_count_q;
      err_illegal_d  = retire && e_illegal_q;
      err_div0_d     = retire && div0;

      if (retire || accept) begin
         e_valid_d = accept;
      end
      if (retire) begin
         retire_count_d = retire_count_q + 32'd1;
      end
      if (accept) begin
         e_rd_d      = in_rd;
         e_illegal_d = is_illegal(in_op);
         alu_a_d     = opnd_a;
         alu_b_d     = opnd_b;
         alu_op_d    = in_op;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         e_valid_q      <= 1'b0;
         e_rd_q         <= '0;
         e_illegal_q    <= 1'b0;
         alu_a_q        <= '0;
         alu_b_q        <= '0;
         alu_op_q       <= '0;
         retire_count_q <= '0;
         err_illegal_q  <= 1'b0;
         err_div0_q     <= 1'b0;
      end else begin
         e_valid_q      <= e_valid_d;
         e_rd_q         <= e_rd_d;
         e_illegal_q    <= e_illegal_d;
         alu_a_q        <= alu_a_d;
         alu_b_q        <= alu_b_d;
         alu_op_q       <= alu_op_d;
         retire_count_q <= retire_count_d;
         err_illegal_q  <= err_illegal_d;
         err_div0_q     <= err_div0_d;
      end
   end

   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign alu_op       = alu_op_q;
   assign wb_valid     = e_valid_q;
   assign wb_rd        = e_rd_q;
   assign wb_data      = suppress ? '0 : alu_result;
   assign err_illegal  = err_illegal_q;
   assign err_div0     = err_div0_q;
   assign retire_count = retire_count_q;

endmodule
